// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: sequencer state, per-stage control bundle and
// RV32 opcode constants that the hazard unit also decodes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } pipe_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_BUBBLE = pipe_ctrl_t'(7'b0000_111);
    localparam pipe_ctrl_t CTRL_FREEZE = pipe_ctrl_t'(7'b0001_001);
    localparam pipe_ctrl_t CTRL_BRANCH = pipe_ctrl_t'(7'b1111_110);
    localparam pipe_ctrl_t CTRL_HAZARD = pipe_ctrl_t'(7'b0011_010);
    localparam pipe_ctrl_t CTRL_IMISS  = pipe_ctrl_t'(7'b0111_100);
    localparam pipe_ctrl_t CTRL_FLOW   = pipe_ctrl_t'(7'b1111_000);

    // Controls for a cycle in which data memory is not holding the pipe.
    function automatic pipe_ctrl_t advance_ctrl(input logic branch_taken,
                                                input logic hazard_stall,
                                                input logic imem_ready);
        if (branch_taken)     return CTRL_BRANCH;
        else if (hazard_stall) return CTRL_HAZARD;
        else if (!imem_ready)  return CTRL_IMISS;
        else                   return CTRL_FLOW;
    endfunction

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Request/enable bundle between the hazard/branch/memory sources and the sequencer.
// Optional PIPE_PERF_EN adds the performance counter outputs.
interface pipe_seq_ctrl_if
`ifdef PIPE_PERF_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    // Level signals sampled every cycle; no valid/ready pairing, the sequencer
    // reacts combinationally and advances state on the rising clock edge.
    logic hazard_stall;
    logic branch_taken;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
    logic mem_timeout;
`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
`endif

    modport master (
        output hazard_stall, branch_taken, imem_ready, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout
`ifdef PIPE_PERF_EN
        , input stall_cycles, flush_events
`endif
    );

    modport slave (
        input  hazard_stall, branch_taken, imem_ready, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, mem_wb_en,
        output if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout
`ifdef PIPE_PERF_EN
        , output stall_cycles, flush_events
`endif
    );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Stall-cycle and branch-flush event counters; both wrap and clear on rst.
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc) stall_d = stall_q + CNT_W'(1);
        if (flush_inc) flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: per-stage enables/flushes, data-memory wait FSM and watchdog.
// Optional PIPE_PERF_EN instantiates pipe_perf_cnt for stall/flush statistics.
module pipe_seq_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
`ifdef PIPE_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    pipe_seq_ctrl_if.slave bus,
    output pipe_state_e state_dbg
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_MAX   = '1;

    pipe_state_e       state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    pipe_ctrl_t        ctrl;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        ctrl          = CTRL_BUBBLE;
        unique case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                // A stalled memory access freezes EX; branch/hazard are re-presented later.
                if (bus.dmem_req && !bus.dmem_ready) begin
                    ctrl       = CTRL_FREEZE;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end else begin
                    ctrl = advance_ctrl(bus.branch_taken, bus.hazard_stall, bus.imem_ready);
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    ctrl       = advance_ctrl(bus.branch_taken, bus.hazard_stall, bus.imem_ready);
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    ctrl = CTRL_FREEZE;
                    if (wait_cnt_q == WCNT_LIMIT) begin
                        state_d       = ST_HALT;
                        mem_timeout_d = 1'b1;
                    end else if (wait_cnt_q != WCNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    end
                end
            end
            ST_HALT: ctrl = CTRL_BUBBLE;
            default: state_d = ST_INIT;
        endcase
        if (rst) ctrl = CTRL_BUBBLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.mem_wb_en    = ctrl.mem_wb_en;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.mem_wb_flush = ctrl.mem_wb_flush;
    assign bus.mem_timeout  = mem_timeout_q;
    assign state_dbg        = state_q;

`ifdef PIPE_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = !rst && !ctrl.pc_en &&
                       (state_q == ST_RUN || state_q == ST_MEM_WAIT);
    // Only the branch redirect loads the PC while also bubbling IF/ID.
    assign flush_inc = ctrl.pc_en && ctrl.if_id_flush;

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_inc    (stall_inc),
        .flush_inc    (flush_inc),
        .stall_cycles (bus.stall_cycles),
        .flush_events (bus.flush_events)
    );
`endif

endmodule
